// File: rtl/fft_pkg.sv
// Shared FFT constants, sweep FSM state encoding and the complex word layout
// used between the FFT core, its result memory and the dump streamer.
package fft_pkg;
  localparam int FFT_ADDR_W   = 5;
  localparam int FFT_DATA_W   = 64;
  localparam int FFT_N_POINTS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } fft_state_e;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } fft_word_t;
endpackage

// File: rtl/fft_result_streamer_if.sv
// Valid/ready result stream carrying one FFT bin per beat with its index and
// an end-of-sweep marker.
interface fft_result_streamer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, out_index, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_index, out_valid, out_last, output out_ready);
endinterface

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head so the outputs come
// straight from flops and stay stable under backpressure.
module stream_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop, do_push;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    // a push into a full FIFO without a pop is dropped; the caller's credit
    // scheme never lets that happen
    do_push = push && ((count_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) e0_d = push_data;
        else                 e1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) e0_d = push_data;
        else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= '0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = e0_q;
endmodule

// File: rtl/fft_result_streamer.sv
// Sweeps the FFT result memory after a start request and streams every bin
// out with index/last. Define FFT_STREAM_BITREV_EN to read the memory in
// bit-reversed address order while still emitting bins in natural order.
module fft_result_streamer
  import fft_pkg::*;
#(
  parameter int ADDR_W   = FFT_ADDR_W,
  parameter int DATA_W   = FFT_DATA_W,
  parameter int N_POINTS = FFT_N_POINTS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_W-1:0]     mem_address,
  input  logic [DATA_W-1:0]     mem_data,
  fft_result_streamer_if.master out_s,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = ADDR_W + 1;
  localparam int PW = DATA_W + ADDR_W + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_POINTS - 1);

  fft_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] infl_idx_q, infl_idx_d;
  logic              infl_last_q, infl_last_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [1:0]        fifo_count;
  logic [PW-1:0]     fifo_head;
  logic              pop, issue;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] nxt_lin, nxt_addr;

  assign pop     = out_s.out_valid && out_s.out_ready;
  // buffered + in flight after this edge; keeping it under 2 rules out overflow
  assign occ     = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = (state_q == ST_READ) && (occ < 3'd2);
  assign nxt_lin = cnt_q[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef FFT_STREAM_BITREV_EN
  always_comb begin
    nxt_addr = '0;
    for (int b = 0; b < ADDR_W; b++) nxt_addr[b] = nxt_lin[ADDR_W-1-b];
  end
`else
  assign nxt_addr = nxt_lin;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    inflight_d    = issue;
    infl_idx_d    = cnt_q[ADDR_W-1:0];
    infl_last_d   = (cnt_q == LAST_CNT);
    mem_address_d = mem_address_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_READ;
          cnt_d         = '0;
          mem_address_d = '0;
        end
      end
      ST_READ: begin
        // mem_address_q is the address presented this cycle; issuing commits it
        if (issue) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) state_d = ST_DRAIN;
          else                   mem_address_d = nxt_addr;
        end
      end
      ST_DRAIN: begin
        if (occ == 3'd0) begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          mem_address_d = '0;
          done_d        = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      inflight_q    <= 1'b0;
      infl_idx_q    <= '0;
      infl_last_q   <= 1'b0;
      mem_address_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      inflight_q    <= inflight_d;
      infl_idx_q    <= infl_idx_d;
      infl_last_q   <= infl_last_d;
      mem_address_q <= mem_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  stream_fifo2 #(.W(PW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({infl_last_q, infl_idx_q, mem_data}),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign out_s.out_valid = (fifo_count != 2'd0);
  assign {out_s.out_last, out_s.out_index, out_s.out_data} = fifo_head;
  assign mem_address = mem_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_fft_result_streamer.sv
// Directed bench for fft_result_streamer: latency table plus backpressure,
// back-to-back, held-start and mid-sweep reset sequences.
module tb_fft_result_streamer;
  import fft_pkg::*;
  localparam int AW = FFT_ADDR_W;
  localparam int DW = FFT_DATA_W;
  localparam int N  = FFT_N_POINTS;

  logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data = '0;
  logic          busy, done;

  fft_result_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  fft_result_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .out_s       (s_if),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];
  always @(posedge clk) mem_data <= mem[mem_address];

  int checks = 0, failures = 0, beats = 0, dones = 0, exp_idx = 0;

  function automatic logic [AW-1:0] amap(int i);
    logic [AW-1:0] v, r;
    v = AW'(i);
    r = v;
`ifdef FFT_STREAM_BITREV_EN
    for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
`endif
    return r;
  endfunction

  function automatic logic [DW-1:0] word(int k);
    fft_word_t w;
    w.re = k;
    w.im = ~k;
    return w;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int lim);
    int n = 0;
    while (!done && n < lim) begin
      step();
      n++;
    end
    chk("done_seen", 64'(done), 64'(1));
  endtask

  task automatic wait_head(int idx, int lim);
    int n = 0;
    while (!(s_if.out_valid && s_if.out_index == AW'(idx)) && n < lim) begin
      step();
      n++;
    end
    chk("head_reached", 64'(s_if.out_index), 64'(idx));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, 64'(s_if.out_valid), 64'(0));
    chk({tag, "_data"},  64'(s_if.out_data),  64'(0));
    chk({tag, "_index"}, 64'(s_if.out_index), 64'(0));
    chk({tag, "_last"},  64'(s_if.out_last),  64'(0));
    chk({tag, "_busy"},  64'(busy),           64'(0));
    chk({tag, "_done"},  64'(done),           64'(0));
    chk({tag, "_addr"},  64'(mem_address),    64'(0));
  endtask

  // Scoreboard: every accepted beat must be the next bin in natural order.
  always @(negedge clk) begin
    if (!rst_n) exp_idx = 0;
    else begin
      if (s_if.out_valid && s_if.out_ready) begin
        chk("beat_idx",  64'(s_if.out_index), 64'(exp_idx));
        chk("beat_data", 64'(s_if.out_data),  64'(word(int'(amap(exp_idx)))));
        chk("beat_last", 64'(s_if.out_last),  64'(exp_idx == N - 1));
        beats++;
        exp_idx = (exp_idx + 1) % N;
      end
      if (done) dones++;
      if (busy) chk("fifo_cnt_le2", 64'(dut.u_fifo.count_q <= 2'd2), 64'(1));
    end
  end

  typedef struct {
    int   cyc;
    logic vld;
    int   idx;
    logic last;
    logic bsy;
    logic dn;
    int   acnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cur;
    int d;
    vecs[0] = '{0,  1'b0, 0,  1'b0, 1'b1, 1'b0, 0};
    vecs[1] = '{1,  1'b0, 0,  1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{2,  1'b1, 0,  1'b0, 1'b1, 1'b0, 2};
    vecs[3] = '{3,  1'b1, 1,  1'b0, 1'b1, 1'b0, 3};
    vecs[4] = '{17, 1'b1, 15, 1'b0, 1'b1, 1'b0, 17};
    vecs[5] = '{32, 1'b1, 30, 1'b0, 1'b1, 1'b0, 31};
    vecs[6] = '{33, 1'b1, 31, 1'b1, 1'b1, 1'b0, 31};
    vecs[7] = '{34, 1'b0, 0,  1'b0, 1'b0, 1'b1, 0};
    vecs[8] = '{35, 1'b0, 0,  1'b0, 1'b0, 1'b0, 0};
    for (int k = 0; k < N; k++) mem[k] = word(k);
    s_if.out_ready = 1'b1;

    // reset state
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    step();
    rst_n = 1'b1;
    step();

    // latency / full-throughput sweep
    beats = 0; dones = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cur = 0;
    foreach (vecs[i]) begin
      while (cur < vecs[i].cyc) begin
        step();
        cur++;
      end
      chk($sformatf("t%0d_valid", vecs[i].cyc), 64'(s_if.out_valid), 64'(vecs[i].vld));
      if (vecs[i].vld) begin
        chk($sformatf("t%0d_index", vecs[i].cyc), 64'(s_if.out_index), 64'(vecs[i].idx));
        chk($sformatf("t%0d_data", vecs[i].cyc), 64'(s_if.out_data),
            64'(word(int'(amap(vecs[i].idx)))));
        chk($sformatf("t%0d_last", vecs[i].cyc), 64'(s_if.out_last), 64'(vecs[i].last));
      end
      chk($sformatf("t%0d_busy", vecs[i].cyc), 64'(busy), 64'(vecs[i].bsy));
      chk($sformatf("t%0d_done", vecs[i].cyc), 64'(done), 64'(vecs[i].dn));
      chk($sformatf("t%0d_addr", vecs[i].cyc), 64'(mem_address), 64'(amap(vecs[i].acnt)));
    end
    chk("sweep1_beats", 64'(beats), 64'(32));
    chk("sweep1_dones", 64'(dones), 64'(1));

    // backpressure: freeze at head index 5 for 10 cycles
    beats = 0; dones = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_head(5, 50);
    s_if.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 64'(s_if.out_valid), 64'(1));
      chk("bp_index", 64'(s_if.out_index), 64'(5));
      chk("bp_data",  64'(s_if.out_data),  64'(word(int'(amap(5)))));
      chk("bp_addr",  64'(mem_address),    64'(amap(7)));
    end
    s_if.out_ready = 1'b1;
    wait_done(100);
    step();
    chk("bp_beats", 64'(beats), 64'(32));
    chk("bp_dones", 64'(dones), 64'(1));

    // three back-to-back sweeps with random backpressure
    beats = 0; dones = 0; d = 0;
    start = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      s_if.out_ready = 1'($urandom_range(0, 1));
      step();
      if (done) d++;
      if (d == 3) break;
    end
    start = 1'b0;
    s_if.out_ready = 1'b1;
    step();
    step();
    chk("b2b_beats", 64'(beats), 64'(96));
    chk("b2b_dones", 64'(dones), 64'(3));
    chk("b2b_idle",  64'(busy),  64'(0));

    // start held 40 cycles plus a stray pulse mid-sweep
    beats = 0; dones = 0;
    s_if.out_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 19) s_if.out_ready = 1'b1;
    end
    start = 1'b0;
    chk("held_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 5; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200);
    for (int i = 0; i < 5; i++) step();
    chk("held_idle",  64'(busy),  64'(0));
    chk("held_dones", 64'(dones), 64'(1));
    chk("held_beats", 64'(beats), 64'(32));
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && !s_if.out_valid; i++) step();
    chk("restart_valid", 64'(s_if.out_valid), 64'(1));
    chk("restart_index", 64'(s_if.out_index), 64'(0));
    wait_done(100);
    step();
    chk("restart_beats", 64'(beats), 64'(64));
    chk("restart_dones", 64'(dones), 64'(2));

    // asynchronous reset mid-sweep at head index 12
    beats = 0; dones = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_head(12, 50);
    #1 rst_n = 1'b0;
    #1 chk_zero("midrst");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("midrst_dones", 64'(dones), 64'(0));
    chk("midrst_beats", 64'(beats), 64'(12));
    chk("midrst_idle",  64'(busy),  64'(0));
    beats = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100);
    step();
    chk("post_rst_beats", 64'(beats), 64'(32));
    chk("post_rst_dones", 64'(dones), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_result_streamer.md
Name: fft_result_streamer

Overview:
- Downstream of the radix-2 FFT core: on a start pulse after fft_done, sweeps the FFT result memory (32 words × 64 bits, complex) through the shared read port.
- Emits results as a valid/ready stream with index and last markers, for the UART/logic-analyser dump path.
- Absorbs the memory's 1-cycle read latency and consumer backpressure with a 2-entry buffer; sustains 1 beat/cycle when out_ready stays high.

Parameters:
- ADDR_W, 5, memory address width
- DATA_W, 64, memory word width ({re[31:0], im[31:0]}, passed through unchanged)
- N_POINTS, 32, words per sweep; must equal 2**ADDR_W

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  begin a sweep; sampled high for one or more cycles
- mem_address  out  ADDR_W  read address to FFT memory (registered)
- mem_data  in  DATA_W  read data, valid 1 cycle after mem_address
- out_data  out  DATA_W  streamed word
- out_index  out  ADDR_W  frequency-bin index of out_data
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_last  out  1  beat is final of sweep (qualified by out_valid)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset: all outputs 0; FSM = IDLE; counters and buffer cleared; any in-flight read discarded.
- FSM states:
  - IDLE: start=1 → READ, issue address 0.
  - READ: issue addresses while credit available; after the final address is issued → DRAIN.
  - DRAIN: wait until the buffer is empty and no read is in flight → IDLE, done=1 for exactly one cycle.
- busy=1 in READ and DRAIN.
- start: level-sampled only in IDLE; a start held across several cycles begins exactly one sweep. start in READ/DRAIN is ignored. start sampled in the same cycle done pulses begins a new sweep (IDLE is re-entered that edge).
- Issue rule: a read issues in a cycle iff (buffer_count + inflight − pop) < 2, where pop = out_valid & out_ready. This guarantees no buffer overflow and full throughput.
- Buffer: 2-entry FIFO of {data, index, last}.
  - Captures mem_data one edge after issue.
  - out_data/out_index/out_last come from the head entry and must remain stable while out_valid & ~out_ready.
- Latency: start sampled at edge E0 → mem_address=0 after E0 → buffer captures at E2 → out_valid high after E2. With out_ready=1 throughout, beats handshake at E3..E34 on consecutive cycles, and done is high after E34.
- Addressing: issue counter runs 0..N_POINTS−1. out_index equals the issued address. out_last=1 only for the entry with index N_POINTS−1. No wrap: the counter stops at N_POINTS−1.
- mem_address: holds last issued value while not issuing; returns to 0 on entering IDLE.
- Reset mid-sweep: outputs drop to 0 asynchronously; no done pulse; the next start restarts from index 0.
- Arithmetic: counters are ADDR_W+1 bits internally to detect the end of sweep. No data arithmetic.

Optional Feature:
- Macro FFT_STREAM_BITREV_EN.
- When defined: mem_address is the ADDR_W-bit bit-reversal of the issue counter, un-scrambling the core's bit-reversed output order. out_index still equals the counter (natural bin order); out_last still marks counter N_POINTS−1.
- When undefined: mem_address equals the counter; no reversal logic is synthesized.

Decomposition:
- Shared package fft_pkg:
  - constants FFT_ADDR_W=5, FFT_DATA_W=64, FFT_N_POINTS=32
  - state enum typedef for IDLE/READ/DRAIN
  - typedef fft_word_t {re, im} 32-bit signed each
- One natural sub-module: stream_fifo2 (2-entry register FIFO: push, pop, count, head fields). The FSM and credit logic stay in the top.

Test Plan:
- out_ready=1, start pulse at E0 (memory word k = {k, ~k}) → out_valid after E2; 32 consecutive beats with index 0..31 and matching data; out_last only on index 31; done single pulse after E34; busy low thereafter.
- out_ready low for 10 cycles starting at beat 5 → out_data/out_index frozen at index 5; mem_address advances at most 2 beyond the head; no beat lost or duplicated; total 32 beats.
- Random out_ready (50%) over 3 back-to-back sweeps → 96 beats in order; buffer_count never exceeds 2.
- start held high 40 cycles, plus an extra pulse mid-sweep → exactly one sweep and one done pulse; a restart after done yields index 0 again.
- rst_n asserted at beat 12 → all outputs 0 immediately, no done; a later start streams the full 0..31 sweep.
- FFT_STREAM_BITREV_EN defined → mem_address sequence 0,16,8,24,4,20,…,31; out_index sequence 0..31; data at index i equals memory word bitrev(i).
